// File: rtl/gray_conv_arb.sv
// Round-robin arbiter that shares one two-stage registered binary<->gray converter
// among NUM_REQ requesters and returns each result tagged with its requester index.
module gray_conv_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_dir,
  input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0]   req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                rsp_valid,
  output logic [ID_W-1:0]                     rsp_id,
  output logic                                rsp_dir,
  output logic [DATA_WIDTH:0]                 rsp_data,
  input  logic                                rsp_ready
);

  localparam int unsigned W = DATA_WIDTH + 1;

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            s1_valid_q, s1_valid_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  logic            s1_dir_q, s1_dir_d;
  logic [W-1:0]    s1_data_q, s1_data_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic            rsp_dir_q, rsp_dir_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;

  logic            s1_en, s2_en;
  logic            win_found, accept;
  logic [ID_W-1:0] win_id;
  logic [ID_W:0]   scan_idx;
  logic [W-1:0]    req_data_sel;
  logic [W-1:0]    b2g, g2b;
  logic            par;

  assign s2_en  = ~rsp_valid_q | rsp_ready;
  assign s1_en  = ~s1_valid_q | s2_en;
  assign accept = s1_en & ~rst & win_found;

  // Scan rr_ptr, rr_ptr+1, ... with an explicit modulo so non-power-of-2 counts wrap correctly.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
      end
      if (!win_found && req_valid[scan_idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[win_id] = 1'b1;
    end
  end

  always_comb begin
    req_data_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        req_data_sel = req_data[i*W +: W];
      end
    end
  end

  // Shared converter: both directions computed from S1, selected by the captured direction.
  assign b2g = s1_data_q ^ (s1_data_q >> 1);

  always_comb begin
    g2b = '0;
    par = 1'b0;
    for (int k = int'(DATA_WIDTH); k >= 0; k--) begin
      par    = par ^ s1_data_q[k];
      g2b[k] = par;
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    s1_valid_d  = s1_valid_q;
    s1_id_d     = s1_id_q;
    s1_dir_d    = s1_dir_q;
    s1_data_d   = s1_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_dir_d   = rsp_dir_q;
    rsp_data_d  = rsp_data_q;

    if (accept) begin
      rr_ptr_d = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
    end

    if (s1_en) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_id_d   = win_id;
        s1_dir_d  = req_dir[win_id];
        s1_data_d = req_data_sel;
      end
    end

    if (s2_en) begin
      rsp_valid_d = s1_valid_q;
      rsp_id_d    = s1_id_q;
      rsp_dir_d   = s1_dir_q;
      rsp_data_d  = s1_dir_q ? b2g : g2b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s1_dir_q    <= 1'b0;
      s1_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_dir_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      s1_dir_q    <= s1_dir_d;
      s1_data_q   <= s1_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_dir_q   <= rsp_dir_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_dir   = rsp_dir_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_gray_conv_arb.sv
// Bench for gray_conv_arb: directed scenarios plus random traffic, all checked against a
// queue-based model (capacity-2 buffer, round-robin scan, B2G arithmetic and its inverse table).
module tb_gray_conv_arb;

  localparam int N  = 4;
  localparam int W  = 9;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_dir, req_ready;
  logic [N*W-1:0] req_data;
  logic           rsp_valid, rsp_dir, rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_data;

  logic           rst3;
  logic [2:0]     rv3, rd3, rr3;
  logic [3*W-1:0] rdata3;
  logic           rspv3, rspdir3;
  logic [1:0]     rspid3;
  logic [W-1:0]   rspdata3;

  gray_conv_arb #(.NUM_REQ(N), .DATA_WIDTH(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_dir   (req_dir),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_dir   (rsp_dir),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  gray_conv_arb #(.NUM_REQ(3), .DATA_WIDTH(8)) u_dut3 (
    .clk       (clk),
    .rst       (rst3),
    .req_valid (rv3),
    .req_dir   (rd3),
    .req_data  (rdata3),
    .req_ready (rr3),
    .rsp_valid (rspv3),
    .rsp_id    (rspid3),
    .rsp_dir   (rspdir3),
    .rsp_data  (rspdata3),
    .rsp_ready (1'b1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int dir;
    int res;
    int vis;
  } item_t;

  item_t q[$];
  int    mptr;
  int    cyc;
  int    last_win;
  int    inv[512];
  int    errors;
  int    checks;

  logic [N-1:0]  samp_ready;
  logic          samp_valid;
  logic [IW-1:0] samp_id;
  logic          samp_dir;
  logic [W-1:0]  samp_data;
  logic [2:0]    samp_rr3;

  function automatic int b2g(input int v);
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare DUT against the model at the falling edge, then advance the model.
  task automatic do_cycle();
    logic [N-1:0] exp_rdy;
    int           win;
    bit           exp_v;
    item_t        it;
    @(negedge clk);
    win = -1;
    if (!rst && !(q.size() == 2 && !rsp_ready)) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (mptr + k) % N;
        if (win < 0 && req_valid[j]) win = j;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    exp_v = (q.size() > 0) && (q[0].vis <= cyc);
    check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    if (exp_v) begin
      check("rsp_id", 32'(rsp_id), q[0].id);
      check("rsp_dir", 32'(rsp_dir), q[0].dir);
      check("rsp_data", 32'(rsp_data), q[0].res);
    end
    samp_ready = req_ready;
    samp_valid = rsp_valid;
    samp_id    = rsp_id;
    samp_dir   = rsp_dir;
    samp_data  = rsp_data;
    samp_rr3   = rr3;
    last_win   = win;
    if (rst) begin
      q.delete();
      mptr = 0;
    end else begin
      if (exp_v && rsp_ready) begin
        void'(q.pop_front());
        if (q.size() > 0 && q[0].vis < cyc + 1) q[0].vis = cyc + 1;
      end
      if (win >= 0) begin
        it.id  = win;
        it.dir = int'(req_dir[win]);
        it.res = req_dir[win] ? b2g(int'(req_data[win*W +: W])) : inv[req_data[win*W +: W]];
        it.vis = cyc + 2;
        q.push_back(it);
        mptr = (win + 1) % N;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    do_cycle();
    rst = 1'b0;
  endtask

  initial begin
    int            acc;
    int            nresp;
    int            v;
    int            bound;
    logic [N-1:0]  eg;
    logic [W-1:0]  held;
    errors = 0; checks = 0; mptr = 0; cyc = 0; last_win = -1;
    rst = 1'b1; rst3 = 1'b1;
    req_valid = '0; req_dir = '0; req_data = '0; rsp_ready = 1'b1;
    rv3 = '0; rd3 = '0; rdata3 = '0;
    for (int x = 0; x < 512; x++) inv[b2g(x)] = x;

    // Requests presented during reset are never accepted
    req_valid = '1;
    do_cycle();
    check("rst_rsp_valid", 32'(samp_valid), 0);
    check("rst_rsp_data", 32'(samp_data), 0);
    do_cycle();
    check("rst_no_grant", 32'(samp_ready), 0);
    rst = 1'b0; rst3 = 1'b0; req_valid = '0;
    do_cycle();

    // Single binary->gray and gray->binary requests from requester 1
    req_valid = 4'b0010; req_dir = 4'b0010; req_data[W +: W] = 9'h0B5;
    do_cycle();
    check("single_grant", 32'(samp_ready), 32'h2);
    req_valid = '0;
    do_cycle();
    check("single_lat1", 32'(samp_valid), 0);
    do_cycle();
    check("single_b2g_valid", 32'(samp_valid), 1);
    check("single_b2g_id", 32'(samp_id), 1);
    check("single_b2g_dir", 32'(samp_dir), 1);
    check("single_b2g_data", 32'(samp_data), 32'h0EF);
    req_valid = 4'b0010; req_dir = 4'b0000; req_data[W +: W] = 9'h0EF;
    do_cycle();
    req_valid = '0;
    do_cycle();
    do_cycle();
    check("single_g2b_valid", 32'(samp_valid), 1);
    check("single_g2b_dir", 32'(samp_dir), 0);
    check("single_g2b_data", 32'(samp_data), 32'h0B5);

    // Full contention: strict 0,1,2,3 rotation, responses two cycles behind
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(i * 37 + 5);
    req_dir = 4'b0101; req_valid = '1; rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      do_cycle();
      eg = '0; eg[c % N] = 1'b1;
      check("cont_grant", 32'(samp_ready), 32'(eg));
      if (c >= 2) begin
        check("cont_rsp_valid", 32'(samp_valid), 1);
        check("cont_rsp_id", 32'(samp_id), (c - 2) % N);
      end
      if (last_win >= 0) req_data[last_win*W +: W] = W'($urandom);
    end
    req_valid = '0;
    repeat (3) do_cycle();

    // Backpressure: two accepts then stall, outputs frozen, ordered release
    do_reset();
    req_valid = '1; rsp_ready = 1'b0; acc = 0; held = '0;
    for (int c = 0; c < 5; c++) begin
      do_cycle();
      if (samp_ready != 0) acc++;
      if (c == 2) held = samp_data;
      if (c > 2) check("bp_data_stable", 32'(samp_data), 32'(held));
      if (c >= 2) check("bp_id_stable", 32'(samp_id), 0);
      if (last_win >= 0) req_data[last_win*W +: W] = W'($urandom);
    end
    check("bp_accepts", acc, 2);
    rsp_ready = 1'b1;
    do_cycle();
    check("bp_rel0_id", 32'(samp_id), 0);
    check("bp_recover_grant", 32'(samp_ready), 32'h4);
    do_cycle();
    check("bp_rel1_valid", 32'(samp_valid), 1);
    check("bp_rel1_id", 32'(samp_id), 1);
    req_valid = '0;
    repeat (4) do_cycle();

    // Reset while both stages are full
    req_valid = '1; rsp_ready = 1'b0;
    repeat (3) do_cycle();
    do_reset();
    rsp_ready = 1'b1;
    do_cycle();
    check("mid_rst_valid", 32'(samp_valid), 0);
    check("mid_rst_data", 32'(samp_data), 0);
    check("mid_rst_ptr", 32'(samp_ready), 32'h1);
    req_valid = '0; nresp = 0;
    for (int c = 0; c < 5; c++) begin
      do_cycle();
      if (samp_valid) nresp++;
    end
    check("mid_rst_no_stale", nresp, 1);

    // Three-requester instance: pointer wraps from 2 back to 0
    rv3 = 3'b100; rdata3 = {9'h011, 9'h022, 9'h033}; rd3 = 3'b111;
    do_cycle();
    check("wrap3_first", 32'(samp_rr3), 32'h4);
    rv3 = 3'b101;
    do_cycle();
    check("wrap3_second", 32'(samp_rr3), 32'h1);
    rv3 = '0;
    do_cycle();

    // Random traffic with held-until-accepted requests and random backpressure
    for (int c = 0; c < 400; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_win == i) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_dir[i]   = 1'($urandom_range(0, 1));
          req_data[i*W +: W] = W'($urandom);
        end
      end
      do_cycle();
    end
    req_valid = '0;

    // Exhaustive round trip: every 9-bit value through B2G, then its gray code through G2B
    for (int pass = 0; pass < 2; pass++) begin
      v = 0; bound = 0;
      req_valid = 4'b0001; req_dir = (pass == 0) ? 4'b0001 : 4'b0000;
      req_data[0 +: W] = (pass == 0) ? W'(0) : W'(b2g(0));
      while (v < 512 && bound < 3000) begin
        rsp_ready = ($urandom_range(0, 3) != 0);
        do_cycle();
        bound++;
        if (last_win == 0) begin
          v++;
          if (v < 512) req_data[0 +: W] = (pass == 0) ? W'(v) : W'(b2g(v));
          else req_valid = '0;
        end
      end
      check("exh_all_issued", v, 512);
      req_valid = '0;
    end

    rsp_ready = 1'b1;
    bound = 0;
    while (q.size() > 0 && bound < 20) begin
      do_cycle();
      bound++;
    end
    check("drain_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
